// File: rtl/rgb_pwm_decoder.sv
// rtl/rgb_pwm_decoder.sv - measures per-window PWM duty of each RGB line and infers the hue sector
module rgb_pwm_decoder #(
   parameter int PWM_INTERVAL = 1200,
   parameter bit ACTIVE_LOW   = 1'b1,
   localparam int DW          = $clog2(PWM_INTERVAL + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          RGB_R,
   input  logic          RGB_G,
   input  logic          RGB_B,
   output logic [DW-1:0] R_duty,
   output logic [DW-1:0] G_duty,
   output logic [DW-1:0] B_duty,
   output logic          duty_valid,
   output logic [2:0]    sector,
   output logic          sector_valid,
   output logic          sector_change
);

   localparam logic [1:0] DISCARD = 2'd0;
   localparam logic [1:0] PRIME   = 2'd1;
   localparam logic [1:0] TRACK   = 2'd2;

   localparam logic [2:0] C_LOW  = 3'd0;
   localparam logic [2:0] C_HIGH = 3'd1;
   localparam logic [2:0] C_INC  = 3'd2;
   localparam logic [2:0] C_DEC  = 3'd3;
   localparam logic [2:0] C_MID  = 3'd4;

   localparam logic [DW-1:0] LAST = DW'(PWM_INTERVAL - 1);
   localparam logic [DW-1:0] FULL = DW'(PWM_INTERVAL);
   localparam logic [2:0]    UNKNOWN = 3'd7;

   // channel index 0 = red, 1 = green, 2 = blue throughout
   logic [2:0]    pin;
   logic [2:0]    sync1;
   logic [2:0]    sync2;
   logic [2:0]    lit;
   logic [DW-1:0] cnt;
   logic          win_end;
   logic [1:0]    state;
   logic          eval_pend;
   logic [DW-1:0] acc  [3];
   logic [DW-1:0] duty [3];
   logic [DW-1:0] prev [3];
   logic [2:0]    cls  [3];
   logic [2:0]    sector_next;

   assign pin     = {RGB_B, RGB_G, RGB_R};
   assign lit     = ACTIVE_LOW ? ~sync2 : sync2;
   assign win_end = (cnt == LAST);

   assign R_duty = duty[0];
   assign G_duty = duty[1];
   assign B_duty = duty[2];

   // extremes win over the trend so a pinned channel reads HIGH/LOW, not INC/DEC
   function automatic logic [2:0] classify(input logic [DW-1:0] cur, input logic [DW-1:0] old);
      if (cur == FULL)
         return C_HIGH;
      else if (cur == '0)
         return C_LOW;
      else if (cur > old)
         return C_INC;
      else if (cur < old)
         return C_DEC;
      else
         return C_MID;
   endfunction

   always_comb begin
      for (int i = 0; i < 3; i++)
         cls[i] = classify(duty[i], prev[i]);
      sector_next = UNKNOWN;
      case ({cls[0], cls[1], cls[2]})
         {C_HIGH, C_INC,  C_LOW }: sector_next = 3'd0;
         {C_DEC,  C_HIGH, C_LOW }: sector_next = 3'd1;
         {C_LOW,  C_HIGH, C_INC }: sector_next = 3'd2;
         {C_LOW,  C_DEC,  C_HIGH}: sector_next = 3'd3;
         {C_INC,  C_LOW,  C_HIGH}: sector_next = 3'd4;
         {C_HIGH, C_LOW,  C_DEC }: sector_next = 3'd5;
         default:                  sector_next = UNKNOWN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1         <= '0;
         sync2         <= '0;
         cnt           <= '0;
         state         <= DISCARD;
         eval_pend     <= 1'b0;
         duty_valid    <= 1'b0;
         sector        <= UNKNOWN;
         sector_valid  <= 1'b0;
         sector_change <= 1'b0;
         for (int i = 0; i < 3; i++) begin
            acc[i]  <= '0;
            duty[i] <= '0;
            prev[i] <= '0;
         end
      end else begin
         sync1         <= pin;
         sync2         <= sync1;
         cnt           <= win_end ? '0 : cnt + DW'(1);
         duty_valid    <= 1'b0;
         eval_pend     <= 1'b0;
         sector_valid  <= 1'b0;
         sector_change <= 1'b0;

         // the sample on the window-end edge belongs to the closing window
         for (int i = 0; i < 3; i++)
            acc[i] <= win_end ? '0 : acc[i] + DW'(lit[i]);

         if (win_end) begin
            case (state)
               DISCARD: state <= PRIME;
               PRIME: begin
                  state      <= TRACK;
                  duty_valid <= 1'b1;
                  for (int i = 0; i < 3; i++)
                     duty[i] <= acc[i] + DW'(lit[i]);
               end
               TRACK: begin
                  duty_valid <= 1'b1;
                  eval_pend  <= 1'b1;
                  for (int i = 0; i < 3; i++)
                     duty[i] <= acc[i] + DW'(lit[i]);
               end
               default: state <= DISCARD;
            endcase
         end

         if (duty_valid) begin
            for (int i = 0; i < 3; i++)
               prev[i] <= duty[i];
         end

         if (eval_pend) begin
            sector        <= sector_next;
            sector_valid  <= 1'b1;
            sector_change <= (sector_next != sector) && (sector_next != UNKNOWN) && (sector != UNKNOWN);
         end
      end
   end

endmodule
